// File: rtl/squat_fwd_sched.sv
// squat_fwd_sched: forwarding scheduler for the SQUAT 4x4 Utopia switch.
// Picks an Rx buffer round-robin, drops the cell on a bad HEC, looks up the
// per-VPI forwarding entry, then loads the cell into every Tx buffer in the
// forward mask as each one becomes free, and finally pops the Rx buffer.
// Optional macro SQUAT_FWD_TIMEOUT_EN: abandons a cell whose remaining Tx
// ports stay busy for TIMEOUT cycles and adds the timeout_cnt output.
module squat_fwd_sched #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       rx_valid,
   output logic [1:0]       rx_sel,
   output logic [3:0]       rx_pop,
   input  logic [7:0]       hdr_vpi,
   input  logic             hec_ok,
   output logic             lut_rd,
   output logic [7:0]       lut_addr,
   input  logic [15:0]      lut_data,
   input  logic [3:0]       tx_free,
   output logic [3:0]       tx_load,
   output logic [11:0]      nni_vpi,
   output logic             busy,
   output logic [CNT_W-1:0] hec_err_cnt,
`ifdef SQUAT_FWD_TIMEOUT_EN
   output logic [CNT_W-1:0] timeout_cnt,
`endif
   output logic [CNT_W-1:0] unrouted_cnt
);

   typedef enum logic [1:0] {IDLE, CHECK, LOOKUP, FWD} state_t;

   // A zero stall limit would abandon every multicast cell immediately.
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("squat_fwd_sched: TIMEOUT must be at least 1");
   end

   state_t            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [3:0]        pending_q, pending_d;
   logic [11:0]       nni_vpi_q, nni_vpi_d;
   logic [CNT_W-1:0]  hec_err_cnt_q, hec_err_cnt_d;
   logic [CNT_W-1:0]  unrouted_cnt_q, unrouted_cnt_d;
   logic              grant_found;
   logic [1:0]        grant_idx;
   logic [1:0]        cand;
   logic [3:0]        pop_c;
   logic [3:0]        load_c;
   logic              rd_c;
`ifdef SQUAT_FWD_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);
   logic [STALL_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
`endif

   // Round-robin search: first requesting buffer starting at rr_ptr.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = rr_ptr_q;
      cand        = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = rr_ptr_q + 2'(k);
         if (!grant_found && rx_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Next-state logic plus the Mealy pulses (pop, load, read strobe).
   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      rr_ptr_d       = rr_ptr_q;
      pending_d      = pending_q;
      nni_vpi_d      = nni_vpi_q;
      hec_err_cnt_d  = hec_err_cnt_q;
      unrouted_cnt_d = unrouted_cnt_q;
      pop_c          = 4'b0000;
      load_c         = 4'b0000;
      rd_c           = 1'b0;
`ifdef SQUAT_FWD_TIMEOUT_EN
      stall_d        = stall_q;
      timeout_cnt_d  = timeout_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               sel_d    = grant_idx;
               rr_ptr_d = grant_idx + 2'd1;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            if (!hec_ok) begin
               pop_c = 4'b0001 << sel_q;
               if (hec_err_cnt_q != '1) hec_err_cnt_d = hec_err_cnt_q + CNT_W'(1);
               state_d = IDLE;
            end else begin
               rd_c    = 1'b1;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            nni_vpi_d = lut_data[11:0];
            pending_d = lut_data[15:12];
`ifdef SQUAT_FWD_TIMEOUT_EN
            stall_d   = '0;
`endif
            if (lut_data[15:12] == 4'b0000) begin
               pop_c = 4'b0001 << sel_q;
               if (unrouted_cnt_q != '1) unrouted_cnt_d = unrouted_cnt_q + CNT_W'(1);
               state_d = IDLE;
            end else begin
               state_d = FWD;
            end
         end
         FWD: begin
            // Each port loads at most once: its pending bit clears on load.
            load_c    = pending_q & tx_free;
            pending_d = pending_q & ~tx_free;
            if (pending_d == 4'b0000) begin
               pop_c   = 4'b0001 << sel_q;
               state_d = IDLE;
            end
`ifdef SQUAT_FWD_TIMEOUT_EN
            else if (load_c != 4'b0000) begin
               stall_d = '0;
            end else if (32'(stall_q) + 1 >= TIMEOUT) begin
               pop_c     = 4'b0001 << sel_q;
               pending_d = 4'b0000;
               if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
               state_d   = IDLE;
            end else begin
               stall_d = stall_q + STALL_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses are suppressed while reset is asserted so an abandoned cell never pops.
   always_comb begin
      rx_pop   = rst ? pop_c  : 4'b0000;
      tx_load  = rst ? load_c : 4'b0000;
      lut_rd   = rst ? rd_c   : 1'b0;
      lut_addr = (rst && rd_c) ? hdr_vpi : 8'h00;
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         sel_q          <= 2'd0;
         rr_ptr_q       <= 2'd0;
         pending_q      <= 4'b0000;
         nni_vpi_q      <= 12'h000;
         hec_err_cnt_q  <= '0;
         unrouted_cnt_q <= '0;
`ifdef SQUAT_FWD_TIMEOUT_EN
         stall_q        <= '0;
         timeout_cnt_q  <= '0;
`endif
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         rr_ptr_q       <= rr_ptr_d;
         pending_q      <= pending_d;
         nni_vpi_q      <= nni_vpi_d;
         hec_err_cnt_q  <= hec_err_cnt_d;
         unrouted_cnt_q <= unrouted_cnt_d;
`ifdef SQUAT_FWD_TIMEOUT_EN
         stall_q        <= stall_d;
         timeout_cnt_q  <= timeout_cnt_d;
`endif
      end
   end

   assign rx_sel       = sel_q;
   assign nni_vpi      = nni_vpi_q;
   assign busy         = (state_q != IDLE);
   assign hec_err_cnt  = hec_err_cnt_q;
   assign unrouted_cnt = unrouted_cnt_q;
`ifdef SQUAT_FWD_TIMEOUT_EN
   assign timeout_cnt  = timeout_cnt_q;
`endif

endmodule

// File: tb/tb_squat_fwd_sched.sv
// Directed testbench for squat_fwd_sched: reset, round-robin, HEC drop,
// unrouted drop, multicast with backpressure, mid-cell reset and (when
// SQUAT_FWD_TIMEOUT_EN is defined) the FWD stall timeout.
module tb_squat_fwd_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rx_valid;
   logic [1:0]  rx_sel;
   logic [3:0]  rx_pop;
   logic [7:0]  hdr_vpi;
   logic        hec_ok;
   logic        lut_rd;
   logic [7:0]  lut_addr;
   logic [15:0] lut_data;
   logic [3:0]  tx_free;
   logic [3:0]  tx_load;
   logic [11:0] nni_vpi;
   logic        busy;
   logic [15:0] hec_err_cnt;
   logic [15:0] unrouted_cnt;
`ifdef SQUAT_FWD_TIMEOUT_EN
   logic [15:0] timeout_cnt;
`endif

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

`ifdef SQUAT_FWD_TIMEOUT_EN
   squat_fwd_sched #(.CNT_W(16), .TIMEOUT(8)) dut (
`else
   squat_fwd_sched #(.CNT_W(16), .TIMEOUT(1024)) dut (
`endif
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_sel(rx_sel), .rx_pop(rx_pop),
      .hdr_vpi(hdr_vpi), .hec_ok(hec_ok), .lut_rd(lut_rd), .lut_addr(lut_addr),
      .lut_data(lut_data), .tx_free(tx_free), .tx_load(tx_load), .nni_vpi(nni_vpi),
      .busy(busy), .hec_err_cnt(hec_err_cnt),
`ifdef SQUAT_FWD_TIMEOUT_EN
      .timeout_cnt(timeout_cnt),
`endif
      .unrouted_cnt(unrouted_cnt));

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rx_valid = 4'h0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rx_valid = 4'hF; hec_ok = 1'b1; lut_data = 16'h1ABC; tx_free = 4'hF; hdr_vpi = 8'h11;
      step();
      step();
      #1;
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %0h exp 0", busy); end
      ncmp++; if (rx_sel !== 2'd0) begin nerr++; $display("FAIL reset_rx_sel got %0h exp 0", rx_sel); end
      ncmp++; if (rx_pop !== 4'h0) begin nerr++; $display("FAIL reset_rx_pop got %0h exp 0", rx_pop); end
      ncmp++; if (tx_load !== 4'h0) begin nerr++; $display("FAIL reset_tx_load got %0h exp 0", tx_load); end
      ncmp++; if (lut_rd !== 1'b0) begin nerr++; $display("FAIL reset_lut_rd got %0h exp 0", lut_rd); end
      ncmp++; if (nni_vpi !== 12'h000) begin nerr++; $display("FAIL reset_nni_vpi got %0h exp 0", nni_vpi); end
      ncmp++; if (hec_err_cnt !== 16'h0) begin nerr++; $display("FAIL reset_hec_cnt got %0h exp 0", hec_err_cnt); end
      ncmp++; if (unrouted_cnt !== 16'h0) begin nerr++; $display("FAIL reset_unrouted_cnt got %0h exp 0", unrouted_cnt); end
      rst = 1'b1;
      step();
      ncmp++; if (rx_sel !== 2'd0) begin nerr++; $display("FAIL reset_first_grant got %0h exp 0", rx_sel); end
      ncmp++; if (busy !== 1'b1) begin nerr++; $display("FAIL reset_first_busy got %0h exp 1", busy); end
      $display("test_reset done");
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_sel;
      logic [3:0] exp_pop;
      logic [7:0] exp_addr;
      do_reset();
      rx_valid = 4'hF; hec_ok = 1'b1; lut_data = 16'h1ABC; tx_free = 4'hF;
      for (int k = 0; k < 5; k++) begin
         exp_sel  = 2'(k % 4);
         exp_pop  = 4'b0001 << exp_sel;
         exp_addr = 8'h30 + 8'(k);
         hdr_vpi  = exp_addr;
         step(); #1;   // CHECK
         ncmp++; if (rx_sel !== exp_sel) begin nerr++; $display("FAIL rr_sel cell %0d got %0d exp %0d", k, rx_sel, exp_sel); end
         ncmp++; if (lut_rd !== 1'b1) begin nerr++; $display("FAIL rr_lut_rd cell %0d got %0h exp 1", k, lut_rd); end
         ncmp++; if (lut_addr !== exp_addr) begin nerr++; $display("FAIL rr_lut_addr cell %0d got %0h exp %0h", k, lut_addr, exp_addr); end
         ncmp++; if (rx_pop !== 4'h0) begin nerr++; $display("FAIL rr_check_pop cell %0d got %0h exp 0", k, rx_pop); end
         step(); #1;   // LOOKUP
         ncmp++; if (rx_pop !== 4'h0 || tx_load !== 4'h0) begin nerr++; $display("FAIL rr_lookup_pulses cell %0d got pop %0h load %0h exp 0 0", k, rx_pop, tx_load); end
         step(); #1;   // FWD
         ncmp++; if (tx_load !== 4'h1) begin nerr++; $display("FAIL rr_tx_load cell %0d got %0h exp 1", k, tx_load); end
         ncmp++; if (rx_pop !== exp_pop) begin nerr++; $display("FAIL rr_rx_pop cell %0d got %0h exp %0h", k, rx_pop, exp_pop); end
         ncmp++; if (nni_vpi !== 12'hABC) begin nerr++; $display("FAIL rr_nni_vpi cell %0d got %0h exp abc", k, nni_vpi); end
         step(); #1;   // IDLE
         ncmp++; if (busy !== 1'b0 || rx_pop !== 4'h0) begin nerr++; $display("FAIL rr_idle cell %0d got busy %0h pop %0h exp 0 0", k, busy, rx_pop); end
         $display("rr cell %0d sel %0d vpi %0h", k, rx_sel, nni_vpi);
      end
   endtask

   task automatic test_hec_drop();
      do_reset();
      rx_valid = 4'h4; hec_ok = 1'b0; lut_data = 16'h1ABC; tx_free = 4'hF; hdr_vpi = 8'h42;
      step(); #1;   // CHECK
      ncmp++; if (rx_sel !== 2'd2) begin nerr++; $display("FAIL hec_sel got %0d exp 2", rx_sel); end
      ncmp++; if (rx_pop !== 4'h4) begin nerr++; $display("FAIL hec_pop got %0h exp 4", rx_pop); end
      ncmp++; if (lut_rd !== 1'b0) begin nerr++; $display("FAIL hec_lut_rd got %0h exp 0", lut_rd); end
      ncmp++; if (tx_load !== 4'h0) begin nerr++; $display("FAIL hec_tx_load got %0h exp 0", tx_load); end
      step(); #1;   // IDLE
      rx_valid = 4'h0;
      ncmp++; if (hec_err_cnt !== 16'd1) begin nerr++; $display("FAIL hec_cnt got %0d exp 1", hec_err_cnt); end
      ncmp++; if (busy !== 1'b0 || lut_rd !== 1'b0) begin nerr++; $display("FAIL hec_idle got busy %0h rd %0h exp 0 0", busy, lut_rd); end
      $display("test_hec_drop done");
   endtask

   task automatic test_rr_skip();
      logic [1:0] exp_sel;
      do_reset();
      rx_valid = 4'b1010; hec_ok = 1'b0; tx_free = 4'hF;
      for (int k = 0; k < 3; k++) begin
         exp_sel = (k == 1) ? 2'd3 : 2'd1;
         step(); #1;   // CHECK
         ncmp++; if (rx_sel !== exp_sel) begin nerr++; $display("FAIL skip_sel cell %0d got %0d exp %0d", k, rx_sel, exp_sel); end
         step(); #1;   // IDLE
         ncmp++; if (hec_err_cnt !== 16'(k + 1)) begin nerr++; $display("FAIL skip_cnt cell %0d got %0d exp %0d", k, hec_err_cnt, k + 1); end
      end
      rx_valid = 4'h0;
      $display("test_rr_skip done");
   endtask

   task automatic test_unrouted();
      do_reset();
      rx_valid = 4'h2; hec_ok = 1'b1; lut_data = 16'h0123; tx_free = 4'hF; hdr_vpi = 8'h07;
      step(); #1;   // CHECK
      ncmp++; if (rx_pop !== 4'h0 || lut_rd !== 1'b1) begin nerr++; $display("FAIL unr_check got pop %0h rd %0h exp 0 1", rx_pop, lut_rd); end
      step(); #1;   // LOOKUP
      ncmp++; if (rx_pop !== 4'h2) begin nerr++; $display("FAIL unr_pop got %0h exp 2", rx_pop); end
      ncmp++; if (tx_load !== 4'h0) begin nerr++; $display("FAIL unr_tx_load got %0h exp 0", tx_load); end
      rx_valid = 4'h0;
      step(); #1;   // IDLE
      ncmp++; if (unrouted_cnt !== 16'd1) begin nerr++; $display("FAIL unr_cnt got %0d exp 1", unrouted_cnt); end
      ncmp++; if (nni_vpi !== 12'h123) begin nerr++; $display("FAIL unr_nni_vpi got %0h exp 123", nni_vpi); end
      ncmp++; if (busy !== 1'b0 || tx_load !== 4'h0) begin nerr++; $display("FAIL unr_idle got busy %0h load %0h exp 0 0", busy, tx_load); end
      $display("test_unrouted done");
   endtask

   task automatic test_multicast();
      do_reset();
      rx_valid = 4'h8; hec_ok = 1'b1; lut_data = 16'hF055; tx_free = 4'h0; hdr_vpi = 8'h55;
      step(); #1;   // CHECK
      ncmp++; if (rx_sel !== 2'd3) begin nerr++; $display("FAIL mc_sel got %0d exp 3", rx_sel); end
      step(); #1;   // LOOKUP
      step();       // FWD, first cycle
      tx_free = 4'h5; #1;
      ncmp++; if (tx_load !== 4'h5) begin nerr++; $display("FAIL mc_load1 got %0h exp 5", tx_load); end
      ncmp++; if (rx_pop !== 4'h0) begin nerr++; $display("FAIL mc_pop1 got %0h exp 0", rx_pop); end
      ncmp++; if (nni_vpi !== 12'h055) begin nerr++; $display("FAIL mc_nni1 got %0h exp 055", nni_vpi); end
      for (int c = 0; c < 3; c++) begin
         step();
         tx_free = 4'h0; #1;
         ncmp++; if (tx_load !== 4'h0 || rx_pop !== 4'h0 || busy !== 1'b1) begin nerr++; $display("FAIL mc_stall %0d got load %0h pop %0h busy %0h exp 0 0 1", c, tx_load, rx_pop, busy); end
      end
      step();
      tx_free = 4'hF; #1;   // ports 0 and 2 already loaded: must not reload
      ncmp++; if (tx_load !== 4'hA) begin nerr++; $display("FAIL mc_load2 got %0h exp a", tx_load); end
      ncmp++; if (rx_pop !== 4'h8) begin nerr++; $display("FAIL mc_pop2 got %0h exp 8", rx_pop); end
      ncmp++; if (nni_vpi !== 12'h055) begin nerr++; $display("FAIL mc_nni2 got %0h exp 055", nni_vpi); end
      rx_valid = 4'h0;
      step(); #1;
      ncmp++; if (busy !== 1'b0 || tx_load !== 4'h0) begin nerr++; $display("FAIL mc_idle got busy %0h load %0h exp 0 0", busy, tx_load); end
      $display("test_multicast done");
   endtask

   task automatic test_mid_reset();
      do_reset();
      rx_valid = 4'h1; hec_ok = 1'b1; lut_data = 16'h1ABC; tx_free = 4'h0; hdr_vpi = 8'h01;
      step(); #1;   // CHECK
      step(); #1;   // LOOKUP
      step();       // FWD
      rst = 1'b0; tx_free = 4'hF; #1;
      ncmp++; if (rx_pop !== 4'h0) begin nerr++; $display("FAIL midrst_pop got %0h exp 0", rx_pop); end
      ncmp++; if (tx_load !== 4'h0) begin nerr++; $display("FAIL midrst_load got %0h exp 0", tx_load); end
      rx_valid = 4'h0;
      step(); #1;
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %0h exp 0", busy); end
      ncmp++; if (nni_vpi !== 12'h000) begin nerr++; $display("FAIL midrst_nni got %0h exp 0", nni_vpi); end
      rst = 1'b1;
      $display("test_mid_reset done");
   endtask

`ifdef SQUAT_FWD_TIMEOUT_EN
   task automatic test_timeout();
      logic [3:0] exp_pop;
      do_reset();
      rx_valid = 4'h1; hec_ok = 1'b1; lut_data = 16'h2001; tx_free = 4'h0; hdr_vpi = 8'h01;
      step(); #1;   // CHECK
      step(); #1;   // LOOKUP
      for (int c = 1; c <= 8; c++) begin
         step(); #1;
         exp_pop = (c == 8) ? 4'h1 : 4'h0;
         ncmp++; if (rx_pop !== exp_pop) begin nerr++; $display("FAIL to_pop fwd cycle %0d got %0h exp %0h", c, rx_pop, exp_pop); end
         ncmp++; if (tx_load !== 4'h0) begin nerr++; $display("FAIL to_load fwd cycle %0d got %0h exp 0", c, tx_load); end
      end
      rx_valid = 4'h0;
      step(); #1;
      ncmp++; if (timeout_cnt !== 16'd1) begin nerr++; $display("FAIL to_cnt got %0d exp 1", timeout_cnt); end
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL to_busy got %0h exp 0", busy); end
      $display("test_timeout done");
   endtask
`endif

   initial begin
      rst = 1'b0; rx_valid = 4'h0; hdr_vpi = 8'h00; hec_ok = 1'b0; lut_data = 16'h0000; tx_free = 4'h0;
      test_reset();
      test_round_robin();
      test_hec_drop();
      test_rr_skip();
      test_unrouted();
      test_multicast();
      test_mid_reset();
`ifdef SQUAT_FWD_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
